// File: rtl/obi_instr_mem.sv
// OBI instruction memory with a bench-side preload port, fixed-latency read
// pipeline, sticky out-of-range flag and response counter.
module obi_instr_mem #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        stall_i,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_wdata_i,
  output logic        oob_o,
  output logic [31:0] fetch_cnt_o
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [31:0]   fetch_off, load_off;
  logic          fetch_hit, load_hit;
  logic [AW-1:0] fetch_idx, load_idx;
  logic          load_en;
  logic          unused_off;

  logic          vld_q [LATENCY];
  logic [31:0]   dat_q [LATENCY];
  logic          oob_q;
  logic [31:0]   cnt_q;

  // Offset-based range check avoids overflow of BASE_ADDR + 4*DEPTH.
  assign fetch_off = instr_addr_i - BASE_ADDR;
  assign load_off  = load_addr_i - BASE_ADDR;
  assign fetch_hit = (instr_addr_i >= BASE_ADDR) && (fetch_off < SPAN);
  assign load_hit  = (load_addr_i >= BASE_ADDR) && (load_off < SPAN);
  assign fetch_idx = fetch_off[AW+1:2];
  assign load_idx  = load_off[AW+1:2];
  assign unused_off = ^{fetch_off[31:AW+2], fetch_off[1:0],
                        load_off[31:AW+2], load_off[1:0]};

  assign instr_gnt_o = instr_req_i & ~stall_i & ~load_we_i & rst_ni;
  assign load_en     = load_we_i & load_hit & rst_ni;

  // Memory array deliberately has no reset.
  always_ff @(posedge clk_i) begin
    if (load_en) begin
      mem[load_idx] <= load_wdata_i;
    end
  end

  // Data stages only advance with a valid token, so the last stage holds
  // the most recent response while rvalid is low.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
      oob_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      vld_q[0] <= instr_gnt_o;
      if (instr_gnt_o) begin
        dat_q[0] <= fetch_hit ? mem[fetch_idx] : '0;
      end
      for (int unsigned i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
      if (instr_gnt_o && !fetch_hit) begin
        oob_q <= 1'b1;
      end
      if (instr_rvalid_o) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign instr_rvalid_o = vld_q[LATENCY-1];
  assign instr_rdata_o  = dat_q[LATENCY-1];
  assign oob_o          = oob_q;
  assign fetch_cnt_o    = cnt_q;

endmodule

// File: doc/obi_instr_mem.md
OBI_INSTR_MEM -- requirements
Module: obi_instr_mem

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH, default 1024, number of 32-bit words (power of 2, 16..65536).
REQ-003 SHALL have parameter LATENCY, default 1, cycles from grant to rvalid (legal 1..4).
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_ni  in  1  reset, synchronous, active-low.
REQ-006 instr_req_i  in  1  fetch request from core (OBI req).
REQ-007 instr_addr_i  in  32  fetch byte address; bits [1:0] ignored.
REQ-008 instr_gnt_o  out  1  request accepted this cycle.
REQ-009 instr_rvalid_o  out  1  instr_rdata_o valid this cycle.
REQ-010 instr_rdata_o  out  32  fetched instruction word.
REQ-011 stall_i  in  1  bench-driven grant suppression.
REQ-012 load_we_i  in  1  preload write strobe.
REQ-013 load_addr_i  in  32  preload byte address; bits [1:0] ignored.
REQ-014 load_wdata_i  in  32  preload data word.
REQ-015 oob_o  out  1  sticky flag: a granted fetch was out of range.
REQ-016 fetch_cnt_o  out  32  count of rvalid pulses since reset.

Function
REQ-017 In range: BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH; word index = (addr - BASE_ADDR) >> 2.
REQ-018 instr_gnt_o SHALL be combinational: instr_req_i & ~stall_i & ~load_we_i & rst_ni.
REQ-019 Load has priority: load_we_i high with in-range load_addr_i writes memory at that edge; out-of-range load writes ignored, no flag.
REQ-020 A granted fetch SHALL read memory at the grant edge; a same-cycle load cannot occur (REQ-018), so read-after-write from a prior cycle returns the new word.
REQ-021 Responses SHALL travel a LATENCY-deep shift pipeline (valid + data); instr_rvalid_o high exactly LATENCY cycles after the grant cycle, one per grant, strictly in grant order.
REQ-022 Back-to-back grants every cycle SHALL yield back-to-back rvalids; up to LATENCY responses in flight; no rvalid backpressure.
REQ-023 instr_rdata_o SHALL hold last valid value while instr_rvalid_o low.
REQ-024 Out-of-range granted fetch SHALL return 32'h0000_0000 with rvalid on schedule and set oob_o at the grant edge; oob_o clears only on reset.
REQ-025 fetch_cnt_o SHALL increment on each cycle instr_rvalid_o is high; wraps 32'hFFFF_FFFF -> 0.
REQ-026 instr_req_i with stall_i high SHALL produce no grant and no response; the request is re-evaluated each cycle (address may change, no latching).
REQ-027 Memory contents SHALL be undefined after power-up and SHALL NOT be cleared by reset.

Reset
REQ-028 While rst_ni low at an edge: instr_rvalid_o=0, instr_rdata_o=0, pipeline valids=0, oob_o=0, fetch_cnt_o=0; instr_gnt_o=0.
REQ-029 Reset asserted with responses in flight SHALL drop them; no rvalid for pre-reset grants after rst_ni rises.
REQ-030 Load writes during reset SHALL be ignored.

Verification
REQ-031 LATENCY=1: preload word0=32'h0031_03B3, word1=32'h0000_0013; req addr 0x0 then 0x4 on consecutive cycles -> gnt both cycles, rvalid cycles 1 and 2 with rdata 0x003103B3 then 0x00000013, fetch_cnt_o=2.
REQ-032 LATENCY=3: 4 back-to-back grants at 0x0..0xC -> rvalid 3 cycles after first, 4 consecutive rvalids in address order.
REQ-033 stall_i high 2 cycles with req held -> gnt low 2 cycles, no rvalid; stall_i low -> gnt, rvalid LATENCY later.
REQ-034 Fetch 0x0000_1000 with DEPTH=1024, BASE_ADDR=0 -> rdata 0x00000000, oob_o=1 and remains 1 until reset.
REQ-035 load_we_i and req same cycle -> gnt 0; next cycle req to just-loaded address -> new data returned.
REQ-036 LATENCY=2, grant then rst_ni low 1 cycle -> no rvalid after release, fetch_cnt_o=0, oob_o=0.
